big_line_prefetch: RTL and testbench

- Downstream consumer of the 2048 x 6-bit BIG tile-map memory, which the BIG initialiser loads.
- Tile map is 64 columns x 32 rows; address = {row[4:0], col[5:0]}.
- On request, during blanking, copies one 64-tile row from the memory read port into a double-buffered line buffer. The display path reads that buffer one column at a time.
- Because the row is prefetched, the memory port is free for writes while pixels are being drawn.

---
 rtl/big_line_prefetch.sv | 127 ++++++++++++
 tb/tb_big_line_prefetch.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/big_line_prefetch.sv
// Row prefetcher for the BIG tile map: copies one row into a double-buffered
// line buffer during blanking so the display path never touches the map memory.
//
// state | meaning
// IDLE  | waiting for fetch_req; swaps accepted here only
// ISSUE | issuing one read per granted cycle, col 0..COLS-1
// DRAIN | last read issued, waiting for in-flight returns
// DONE  | back buffer complete, one-cycle fetch_done
module big_line_prefetch #(
  parameter int COLS   = 64,
  parameter int ROW_W  = 5,
  parameter int DATA_W = 6,
  parameter int RD_LAT = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_req,
  input  logic [ROW_W-1:0]                 fetch_row,
  output logic                             fetch_busy,
  output logic                             fetch_done,
  input  logic                             mem_grant,
  output logic                             mem_rd_en,
  output logic [ROW_W+$clog2(COLS)-1:0]    mem_rd_addr,
  input  logic [DATA_W-1:0]                mem_rd_data,
  input  logic                             disp_swap,
  output logic                             swap_err,
  input  logic [$clog2(COLS)-1:0]          disp_col,
  output logic [DATA_W-1:0]                disp_tile
);

  localparam int CW = $clog2(COLS);
  localparam logic [RD_LAT-1:0] LAST_MASK = RD_LAT'(1) << (RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [ROW_W-1:0]  row_q;
  logic [CW-1:0]     col_q;
  logic              front_q;
  logic              back_full_q;
  logic              done_q;
  logic              swap_err_q;
  logic [DATA_W-1:0] tile_q;
  logic [RD_LAT-1:0] vld_q;
  logic [CW-1:0]     tag_q [RD_LAT];

  logic [DATA_W-1:0] line_mem [2*COLS];

  logic issue;
  logic swap_ok;
  logic pending;

  assign issue   = (state_q == ISSUE) && mem_grant;
  assign swap_ok = (state_q == IDLE) && back_full_q;
  // Anything still in the tag pipe after this cycle's capture keeps us draining.
  assign pending = |(vld_q & ~LAST_MASK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      front_q     <= 1'b0;
      back_full_q <= 1'b0;
      done_q      <= 1'b0;
      swap_err_q  <= 1'b0;
      tile_q      <= '0;
      vld_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      done_q     <= 1'b0;
      swap_err_q <= disp_swap && !swap_ok;
      tile_q     <= line_mem[{front_q, disp_col}];

      vld_q[0] <= issue;
      tag_q[0] <= col_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end

      // Swap is applied before a same-cycle fetch so the fetch fills the new back half.
      if (disp_swap && swap_ok) begin
        front_q     <= ~front_q;
        back_full_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            state_q     <= ISSUE;
            row_q       <= fetch_row;
            col_q       <= '0;
            back_full_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (mem_grant) begin
            if (col_q == CW'(COLS - 1)) state_q <= DRAIN;
            else                        col_q   <= col_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!pending) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            back_full_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (vld_q[RD_LAT-1]) line_mem[{~front_q, tag_q[RD_LAT-1]}] <= mem_rd_data;
  end

  assign fetch_busy  = (state_q == ISSUE) || (state_q == DRAIN);
  assign fetch_done  = done_q;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = {row_q, col_q};
  assign swap_err    = swap_err_q;
  assign disp_tile   = tile_q;

endmodule

// File: tb/tb_big_line_prefetch.sv
// Bench for big_line_prefetch: one instance at RD_LAT=1, one at RD_LAT=3, both fed
// by a behavioural tile-map memory; expectations come from a buffer-level model.
module tb_big_line_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       req   [2];
  logic       busy  [2];
  logic       done  [2];
  logic       grant [2];
  logic       rd_en [2];
  logic       swap  [2];
  logic       serr  [2];
  logic [4:0] row_in  [2];
  logic [10:0] rd_addr [2];
  logic [5:0] rd_data [2];
  logic [5:0] dcol    [2];
  logic [5:0] dtile   [2];

  logic [5:0] mem [2048];
  logic [5:0] pa0, pb0, pb1, pb2;

  int n_checks = 0;
  int n_fail   = 0;

  // model: which half is front, whether back is full, contents of each half
  bit         fsel   [2];
  bit         bfull  [2];
  bit         hvalid [2][2];
  logic [5:0] hdata  [2][2][64];

  big_line_prefetch #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst_n[0]), .fetch_req(req[0]), .fetch_row(row_in[0]),
    .fetch_busy(busy[0]), .fetch_done(done[0]), .mem_grant(grant[0]),
    .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]), .mem_rd_data(rd_data[0]),
    .disp_swap(swap[0]), .swap_err(serr[0]), .disp_col(dcol[0]), .disp_tile(dtile[0])
  );

  big_line_prefetch #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst_n[1]), .fetch_req(req[1]), .fetch_row(row_in[1]),
    .fetch_busy(busy[1]), .fetch_done(done[1]), .mem_grant(grant[1]),
    .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]), .mem_rd_data(rd_data[1]),
    .disp_swap(swap[1]), .swap_err(serr[1]), .disp_col(dcol[1]), .disp_tile(dtile[1])
  );

  always @(posedge clk) begin
    pa0 <= rd_en[0] ? mem[rd_addr[0]] : 6'h3F;
    pb0 <= rd_en[1] ? mem[rd_addr[1]] : 6'h3F;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign rd_data[0] = pa0;
  assign rd_data[1] = pb2;

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  task automatic fill_formula();
    for (int a = 0; a < 2048; a++) begin
      logic [10:0] av;
      av = 11'(a);
      mem[a] = {av[8:6], av[2:0]};
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 2048; a++) mem[a] = 6'($urandom);
  endtask

  task automatic run_fetch(input int s, input logic [4:0] row, input logic [127:0] smask,
                           input int ign_cyc, input int swap_cyc, input int rst_cyc,
                           input bit swap0, input logic [5:0] dc,
                           output int done_k, output logic [10:0] last_addr);
    int ecol, last_iss, lat;
    bit bf0, fin, exp_en, exp_done, exp_busy, exp_err;
    lat = lat_of(s);
    bf0 = bfull[s];
    ecol = 0; last_iss = -100; done_k = -1; last_addr = '0; fin = 0;
    req[s] = 1'b1; row_in[s] = row; swap[s] = swap0; grant[s] = 1'b1; dcol[s] = dc;
    @(negedge clk);
    n_checks++;
    if (busy[s] !== 1'b0) begin
      n_fail++; $display("FAIL busy_before_req dut=%0d: got %0b expected 0", s, busy[s]);
    end
    @(posedge clk); #1;
    if (swap0 && bf0) fsel[s] = !fsel[s];
    bfull[s] = 0;
    for (int k = 1; k <= 150 && !fin; k++) begin
      req[s]    = (k == ign_cyc);
      row_in[s] = (k == ign_cyc) ? 5'd7 : row;
      swap[s]   = (k == swap_cyc);
      grant[s]  = (k < 128) ? !smask[k] : 1'b1;
      rst_n[s]  = (k != rst_cyc);
      @(negedge clk);
      if (rst_cyc > 0 && k >= rst_cyc) begin
        n_checks++;
        if (k == rst_cyc) begin
          if ({busy[s], done[s], rd_en[s], serr[s], dtile[s], rd_addr[s]} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut=%0d: got busy=%0b done=%0b en=%0b err=%0b tile=%0h addr=%0h expected all 0",
                     s, busy[s], done[s], rd_en[s], serr[s], dtile[s], rd_addr[s]);
          end
          hvalid[s][!fsel[s]] = 0;
          fsel[s] = 0;
          bfull[s] = 0;
        end else if ({busy[s], done[s], rd_en[s], serr[s]} !== 4'd0) begin
          n_fail++;
          $display("FAIL abort_idle dut=%0d k=%0d: got busy=%0b done=%0b en=%0b err=%0b expected all 0",
                   s, k, busy[s], done[s], rd_en[s], serr[s]);
        end
        if (k == rst_cyc + 8) fin = 1;
      end else begin
        exp_en = grant[s] && (ecol < 64);
        n_checks++;
        if (rd_en[s] !== exp_en) begin
          n_fail++; $display("FAIL rd_en dut=%0d k=%0d: got %0b expected %0b", s, k, rd_en[s], exp_en);
        end
        if (exp_en) begin
          n_checks++;
          if (rd_addr[s] !== {row, 6'(ecol)}) begin
            n_fail++; $display("FAIL rd_addr dut=%0d k=%0d: got %0d expected %0d", s, k, rd_addr[s], {row, 6'(ecol)});
          end
          last_addr = rd_addr[s];
          ecol++;
          last_iss = k;
        end
        exp_done = (ecol == 64) && (k == last_iss + lat + 1);
        exp_busy = !((ecol == 64) && (k >= last_iss + lat + 1));
        exp_err  = (k == 1) ? (swap0 && !bf0) : (k - 1 == swap_cyc);
        n_checks++;
        if (done[s] !== exp_done) begin
          n_fail++; $display("FAIL fetch_done dut=%0d k=%0d: got %0b expected %0b", s, k, done[s], exp_done);
        end
        n_checks++;
        if (busy[s] !== exp_busy) begin
          n_fail++; $display("FAIL fetch_busy dut=%0d k=%0d: got %0b expected %0b", s, k, busy[s], exp_busy);
        end
        n_checks++;
        if (serr[s] !== exp_err) begin
          n_fail++; $display("FAIL swap_err dut=%0d k=%0d: got %0b expected %0b", s, k, serr[s], exp_err);
        end
        if (k >= 2 && hvalid[s][fsel[s]]) begin
          n_checks++;
          if (dtile[s] !== hdata[s][fsel[s]][dc]) begin
            n_fail++; $display("FAIL disp_during_fetch dut=%0d k=%0d: got %0h expected %0h",
                               s, k, dtile[s], hdata[s][fsel[s]][dc]);
          end
        end
        if (exp_done) begin
          fin = 1;
          done_k = k;
          for (int c = 0; c < 64; c++) hdata[s][!fsel[s]][c] = mem[{row, 6'(c)}];
          hvalid[s][!fsel[s]] = 1;
          bfull[s] = 1;
        end
      end
      @(posedge clk); #1;
    end
    req[s] = 1'b0; swap[s] = 1'b0; grant[s] = 1'b1; rst_n[s] = 1'b1;
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL fetch_timeout dut=%0d: got no completion expected done within 150 cycles", s);
    end
  endtask

  task automatic do_swap(input int s);
    bit exp_err;
    exp_err = !bfull[s];
    swap[s] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    swap[s] = 1'b0;
    if (bfull[s]) begin fsel[s] = !fsel[s]; bfull[s] = 0; end
    @(negedge clk);
    n_checks++;
    if (serr[s] !== exp_err) begin
      n_fail++; $display("FAIL idle_swap_err dut=%0d: got %0b expected %0b", s, serr[s], exp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic read_col(input int s, input logic [5:0] c, output logic [5:0] v);
    dcol[s] = c;
    @(posedge clk); #1;
    @(negedge clk);
    v = dtile[s];
    @(posedge clk); #1;
  endtask

  task automatic read_front(input int s);
    for (int c = 0; c <= 64; c++) begin
      if (c < 64) dcol[s] = 6'(c);
      @(negedge clk);
      if (c > 0 && hvalid[s][fsel[s]]) begin
        n_checks++;
        if (dtile[s] !== hdata[s][fsel[s]][c-1]) begin
          n_fail++; $display("FAIL front_col dut=%0d col=%0d: got %0h expected %0h",
                             s, c - 1, dtile[s], hdata[s][fsel[s]][c-1]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset(input int s);
    rst_n[s] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy[s], done[s], rd_en[s], serr[s], dtile[s], rd_addr[s]} !== 21'd0) begin
      n_fail++; $display("FAIL idle_reset_outputs dut=%0d: got nonzero outputs expected all 0", s);
    end
    @(posedge clk); #1;
    rst_n[s] = 1'b1;
    fsel[s] = 0;
    bfull[s] = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({busy[s], done[s], rd_en[s], serr[s], dtile[s], rd_addr[s]} !== 21'd0) begin
        n_fail++; $display("FAIL power_on_reset dut=%0d: got nonzero outputs expected all 0", s);
      end
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    do_swap(0);
    do_swap(1);
  endtask

  task automatic test_basic();
    int dk; logic [10:0] la; logic [5:0] v;
    fill_formula();
    run_fetch(0, 5'd5, '0, 0, 0, 0, 0, 6'd0, dk, la);
    n_checks++;
    if (dk !== 66) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 66", dk); end
    n_checks++;
    if (la !== 11'd383) begin n_fail++; $display("FAIL basic_last_addr: got %0d expected 383", la); end
    do_swap(0);
    read_col(0, 6'd10, v);
    n_checks++;
    if (v !== 6'd42) begin n_fail++; $display("FAIL basic_col10: got %0d expected 42", v); end
    read_front(0);
  endtask

  task automatic test_stall();
    int dk; logic [10:0] la; logic [127:0] m; logic [5:0] v;
    m = '0; m[14:10] = '1; m[40] = 1'b1;
    run_fetch(0, 5'd5, m, 0, 0, 0, 0, 6'd7, dk, la);
    n_checks++;
    if (dk !== 72) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 72", dk); end
    do_swap(0);
    read_front(0);
    read_col(0, 6'd13, v);
    n_checks++;
    if (v !== 6'b101101) begin n_fail++; $display("FAIL stall_col13: got %0h expected 2d", v); end
  endtask

  task automatic test_bad_swap();
    int dk; logic [10:0] la; logic [5:0] v;
    run_fetch(0, 5'd3, '0, 0, 20, 0, 0, 6'd10, dk, la);
    read_col(0, 6'd10, v);
    n_checks++;
    if (v !== 6'd42) begin n_fail++; $display("FAIL badswap_front_kept: got %0d expected 42", v); end
    pulse_reset(0);
    do_swap(0);
    read_col(0, 6'd10, v);
    n_checks++;
    if (v !== 6'd42) begin n_fail++; $display("FAIL reset_swap_front_kept: got %0d expected 42", v); end
  endtask

  task automatic test_simultaneous();
    int dk; logic [10:0] la; logic [5:0] v;
    fill_random();
    mem[{5'd1, 6'd3}] = 6'd3;
    mem[{5'd2, 6'd3}] = 6'd3;
    run_fetch(0, 5'd1, '0, 0, 0, 0, 0, 6'd3, dk, la);
    run_fetch(0, 5'd2, '0, 0, 0, 0, 1, 6'd3, dk, la);
    read_col(0, 6'd3, v);
    n_checks++;
    if (v !== 6'd3) begin n_fail++; $display("FAIL simul_row1_col3: got %0d expected 3", v); end
    read_front(0);
    do_swap(0);
    read_col(0, 6'd3, v);
    n_checks++;
    if (v !== 6'd3) begin n_fail++; $display("FAIL simul_row2_col3: got %0d expected 3", v); end
    read_front(0);
  endtask

  task automatic test_ignored_req();
    int dk; logic [10:0] la;
    fill_formula();
    run_fetch(0, 5'd4, '0, 30, 0, 0, 0, 6'd0, dk, la);
    n_checks++;
    if (la !== 11'd319) begin n_fail++; $display("FAIL ignored_last_addr: got %0d expected 319", la); end
    do_swap(0);
    read_front(0);
  endtask

  task automatic test_reset_mid_fetch();
    int dk; logic [10:0] la;
    fill_formula();
    run_fetch(1, 5'd9, '0, 0, 0, 30, 0, 6'd0, dk, la);
    run_fetch(1, 5'd31, '0, 0, 0, 0, 0, 6'd0, dk, la);
    n_checks++;
    if (dk !== 68) begin n_fail++; $display("FAIL lat3_done_cycle: got %0d expected 68", dk); end
    n_checks++;
    if (la !== 11'd2047) begin n_fail++; $display("FAIL lat3_last_addr: got %0d expected 2047", la); end
    do_swap(1);
    read_front(1);
  endtask

  task automatic test_random();
    int dk, s, sc, ic; logic [10:0] la; logic [127:0] m;
    for (int it = 0; it < 8; it++) begin
      s = it % 2;
      fill_random();
      m = '0;
      for (int k = 1; k < 100; k++) m[k] = ($urandom_range(3) == 0);
      sc = ($urandom_range(1) == 1) ? int'($urandom_range(60, 5)) : 0;
      ic = ($urandom_range(1) == 1) ? int'($urandom_range(60, 2)) : 0;
      run_fetch(s, 5'($urandom), m, ic, sc, 0, 0, 6'($urandom), dk, la);
      if ($urandom_range(1) == 1) do_swap(s);
      read_front(s);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; req[s] = 1'b0; row_in[s] = '0; grant[s] = 1'b1;
      swap[s] = 1'b0; dcol[s] = '0; fsel[s] = 0; bfull[s] = 0;
      hvalid[s][0] = 0; hvalid[s][1] = 0;
    end
    fill_formula();
    test_reset();
    test_basic();
    test_stall();
    test_bad_swap();
    test_simultaneous();
    test_ignored_req();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
